// File: rtl/arb_pkg.sv
// Shared arbitration types and helpers: FSM state encoding, hold-counter width,
// and a generic round-robin pick for use by this and future arbiters.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_e;

    localparam int HOLD_CNT_W = 8;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } rr_pick_t;

    // Search vec from bit ptr upward, wrapping at n; the first set bit wins.
    function automatic rr_pick_t rr_pick(input logic [31:0] vec, input logic [4:0] ptr, input int n);
        rr_pick_t res;
        int       j;
        res = '0;
        for (int k = 31; k >= 0; k--) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) j = j - n;
                if (vec[j[4:0]]) begin
                    res.found = 1'b1;
                    res.idx   = j[4:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_hold_arbiter_if.sv
// Request/grant bundle between N clients (master side) and the arbiter (slave side).
interface rr_hold_arbiter_if #(
    parameter int N = 4
) ();
    localparam int IDW = $clog2(N);

    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic           timeout;

    modport master (
        output req,
        input  grant,
        input  grant_valid,
        input  grant_id,
        input  timeout
    );

    modport slave (
        input  req,
        output grant,
        output grant_valid,
        output grant_id,
        output timeout
    );
endinterface

// File: rtl/rr_pick_comb.sv
// Combinational round-robin pick: scan vec starting at ptr with wrap-around and
// return the absolute index of the first set bit.
module rr_pick_comb #(
    parameter int N = 4
) (
    input  logic [N-1:0]         vec,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);
    localparam int IDW = $clog2(N);

    int             j;
    logic [IDW-1:0] jw;

    // Walk offsets from farthest to nearest so the nearest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        jw    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            jw = IDW'(j);
            if (vec[jw]) begin
                found = 1'b1;
                idx   = jw;
            end
        end
    end
endmodule

// File: rtl/rr_hold_arbiter.sv
// N-way round-robin arbiter with grant hold and optional maximum tenure.
// All outputs are registered; req never reaches an output combinationally.
module rr_hold_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         rst,
    rr_hold_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N);
    localparam logic [IDW:0]            N_W       = (IDW + 1)'(N);
    localparam logic [N-1:0]            ONE_HOT0  = {{(N - 1){1'b0}}, 1'b1};
    localparam bit                      HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [HOLD_CNT_W-1:0]   HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_CNT_W'(MAX_HOLD - 1);

    arb_state_e             state_q, state_d;
    logic [IDW-1:0]         owner_q, owner_d;
    logic [IDW-1:0]         ptr_q, ptr_d;
    logic [HOLD_CNT_W-1:0]  cnt_q, cnt_d;
    logic [N-1:0]           grant_q, grant_d;
    logic                   grant_valid_q, grant_valid_d;
    logic                   timeout_q, timeout_d;

    logic [IDW:0]           owner_inc;
    logic [IDW-1:0]         owner_next;
    logic [IDW-1:0]         pick_ptr;
    logic [N-1:0]           cand;
    logic                   release_ev, expire_ev;
    logic                   pick_found;
    logic [IDW-1:0]         pick_idx;

    // Release takes precedence over expiry; only a still-requesting owner can time out.
    always_comb begin
        owner_inc  = {1'b0, owner_q} + 1'b1;
        owner_next = (owner_inc == N_W) ? '0 : owner_inc[IDW-1:0];
        release_ev = (state_q == ARB_OWNED) && !bus.req[owner_q];
        expire_ev  = (state_q == ARB_OWNED) && bus.req[owner_q] && HOLD_EN && (cnt_q == HOLD_LAST);
        cand       = expire_ev ? (bus.req & ~(ONE_HOT0 << owner_q)) : bus.req;
        pick_ptr   = (release_ev || expire_ev) ? owner_next : ptr_q;
    end

    rr_pick_comb #(.N(N)) u_pick (
        .vec   (cand),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d = ARB_OWNED;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            ARB_OWNED: begin
                if (release_ev) begin
                    ptr_d = owner_next;
                    cnt_d = '0;
                    if (pick_found) owner_d = pick_idx;
                    else            state_d = ARB_IDLE;
                end else if (expire_ev) begin
                    // Sole requester is re-granted in place; grant stays high.
                    ptr_d     = owner_next;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    if (pick_found) owner_d = pick_idx;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        grant_valid_d = (state_d == ARB_OWNED);
        grant_d       = grant_valid_d ? (ONE_HOT0 << owner_d) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            owner_q       <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_id    = owner_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Bench for rr_hold_arbiter: two instances (MAX_HOLD=4 and MAX_HOLD=0) share one
// request vector and are compared against a tenure-based reference model.
module tb_rr_hold_arbiter;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req = '0;

    always #5 clk = ~clk;

    rr_hold_arbiter_if #(.N(N)) bus_a ();
    rr_hold_arbiter_if #(.N(N)) bus_b ();
    assign bus_a.req = req;
    assign bus_b.req = req;

    rr_hold_arbiter #(.N(N), .MAX_HOLD(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    rr_hold_arbiter #(.N(N), .MAX_HOLD(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    int checks   = 0;
    int failures = 0;

    // Model state per instance: owner (-1 = idle), cycles held so far, rr start, last id.
    int m_owner [2];
    int m_held  [2];
    int m_ptr   [2];
    int m_id    [2];
    int m_to    [2];
    int mh      [2] = '{4, 0};

    function automatic int search(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_owner[c] = -1; m_held[c] = 0; m_ptr[c] = 0; m_id[c] = 0; m_to[c] = 0;
        end
    endtask

    task automatic model_step(input int c, input logic [N-1:0] r);
        int o, w;
        logic [N-1:0] masked;
        o = m_owner[c];
        m_to[c] = 0;
        if (o < 0) begin
            w = search(r, m_ptr[c]);
            if (w >= 0) begin m_owner[c] = w; m_held[c] = 1; m_id[c] = w; end
        end else if (!r[o]) begin
            m_ptr[c] = (o + 1) % N;
            w = search(r, m_ptr[c]);
            m_owner[c] = w;
            m_held[c]  = 1;
            if (w >= 0) m_id[c] = w;
        end else if (mh[c] != 0 && m_held[c] == mh[c]) begin
            m_ptr[c] = (o + 1) % N;
            masked = r;
            masked[o] = 1'b0;
            w = search(masked, m_ptr[c]);
            m_owner[c] = (w >= 0) ? w : o;
            m_id[c]    = m_owner[c];
            m_held[c]  = 1;
            m_to[c]    = 1;
        end else begin
            m_held[c] = m_held[c] + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic check_all();
        logic [N-1:0] eg;
        for (int c = 0; c < 2; c++) begin
            eg = (m_owner[c] >= 0) ? (N'(1) << m_owner[c]) : '0;
            if (c == 0) begin
                chk("a_grant",   32'(bus_a.grant),       32'(eg));
                chk("a_valid",   32'(bus_a.grant_valid), 32'(m_owner[c] >= 0));
                chk("a_id",      32'(bus_a.grant_id),    32'(m_id[c]));
                chk("a_timeout", 32'(bus_a.timeout),     32'(m_to[c]));
            end else begin
                chk("b_grant",   32'(bus_b.grant),       32'(eg));
                chk("b_valid",   32'(bus_b.grant_valid), 32'(m_owner[c] >= 0));
                chk("b_id",      32'(bus_b.grant_id),    32'(m_id[c]));
                chk("b_timeout", 32'(bus_b.timeout),     32'(m_to[c]));
            end
        end
    endtask

    task automatic step(input logic [N-1:0] r);
        req = r;
        model_step(0, r);
        model_step(1, r);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] r;

        #2;
        do_reset();
        for (int i = 0; i < 5; i++) step(4'b0000);

        // Idle pick, back-to-back handoff, then idle again.
        step(4'b0110);
        chk("idle_pick", 32'(bus_a.grant), 32'h2);
        step(4'b0100);
        chk("handoff", 32'(bus_a.grant), 32'h4);
        chk("handoff_id", 32'(bus_a.grant_id), 32'd2);
        step(4'b0000);
        chk("to_idle", 32'(bus_a.grant), 32'h0);

        // All requesting: rotation every 4 cycles with a timeout pulse at each switch.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(4'b1111);
            chk("rot_grant", 32'(bus_a.grant), 32'(1 << ((i / 4) % 4)));
            chk("rot_to", 32'(bus_a.timeout), 32'(i > 0 && i % 4 == 0));
            chk("unl_grant", 32'(bus_b.grant), 32'h1);
        end

        // Sole requester: continuous grant, periodic timeout only when bounded.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(4'b0001);
            chk("solo_grant", 32'(bus_a.grant), 32'h1);
            chk("solo_to", 32'(bus_a.timeout), 32'(i > 0 && i % 4 == 0));
            chk("solo_unl_to", 32'(bus_b.timeout), 32'h0);
        end

        // Release coinciding with expiry counts as release.
        do_reset();
        for (int i = 0; i < 4; i++) step(4'b0001);
        step(4'b0010);
        chk("rel_wins_grant", 32'(bus_a.grant), 32'h2);
        chk("rel_wins_to", 32'(bus_a.timeout), 32'h0);

        // Asynchronous reset mid-grant, then arbitration restarts from pointer 0.
        do_reset();
        step(4'b0100);
        step(4'b0100);
        chk("pre_rst_grant", 32'(bus_a.grant), 32'h4);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_grant", 32'(bus_a.grant), 32'h0);
        chk("async_rst_valid", 32'(bus_a.grant_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(4'b1111);
        chk("post_rst_grant", 32'(bus_a.grant), 32'h1);

        // Random traffic with sticky bits so that holds, releases and timeouts all occur.
        r = '0;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            step(r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
